// File: rtl/aes_ctrl_pkg.sv
// Shared types, constants and the round-key index mapping for the AES-128 round sequencer.
package aes_ctrl_pkg;

   localparam int AES_NR    = 10;
   localparam int AES_IDX_W = 4;

   localparam logic [AES_IDX_W-1:0] IDX_NR = AES_IDX_W'(AES_NR);

   typedef enum logic [2:0] {
      S_IDLE,
      S_KEYEXP,
      S_INIT,
      S_ROUND,
      S_FINAL,
      S_DONE
   } aes_ctrl_state_e;

   // Decryption walks the key schedule backwards: round r uses key NR-r.
   function automatic logic [AES_IDX_W-1:0] rk_sel(input logic [AES_IDX_W-1:0] round,
                                                   input logic                 inv);
      return inv ? (IDX_NR - round) : round;
   endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// Loadable round counter with terminal-count compare; shared by key expansion and the round loop.
module aes_round_cnt
   import aes_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 inc,
   input  logic [AES_IDX_W-1:0] load_val,
   input  logic [AES_IDX_W-1:0] term,
   output logic [AES_IDX_W-1:0] cnt,
   output logic [AES_IDX_W-1:0] cnt_nxt,
   output logic                 tc
);

   always_comb begin
      cnt_nxt = cnt;
      if (load)
         cnt_nxt = load_val;
      else if (inc)
         cnt_nxt = cnt + AES_IDX_W'(1);
   end

   assign tc = (cnt == term);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else
         cnt <= cnt_nxt;
   end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 iterative round sequencer: key expansion, initial AddRoundKey, NR-1 rounds, final round.
module aes_round_ctrl
   import aes_ctrl_pkg::*;
(
   input  logic                 ACLK,
   input  logic                 ARST,
   input  logic                 start,
   input  logic                 decrypt,
   input  logic                 key_load,
   input  logic                 abort,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic                 inv,
   output logic                 kexp_en,
   output logic [AES_IDX_W-1:0] kexp_idx,
   output logic                 st_load,
   output logic                 st_en,
   output logic                 mix_en,
   output logic [AES_IDX_W-1:0] rk_idx
);

   aes_ctrl_state_e      state, state_nxt;
   logic                 cnt_load, cnt_inc, cnt_tc;
   logic [AES_IDX_W-1:0] cnt_val, cnt_term, cnt, cnt_nxt;
   logic                 inv_nxt;
   logic                 key_valid, key_stale;
   logic [AES_IDX_W-1:0] rk_nxt;

   aes_round_cnt u_cnt (
      .clk      (ACLK),
      .rst      (ARST),
      .load     (cnt_load),
      .inc      (cnt_inc),
      .load_val (cnt_val),
      .term     (cnt_term),
      .cnt      (cnt),
      .cnt_nxt  (cnt_nxt),
      .tc       (cnt_tc)
   );

   always_comb begin
      state_nxt = state;
      cnt_load  = 1'b0;
      cnt_inc   = 1'b0;
      cnt_val   = AES_IDX_W'(1);
      cnt_term  = IDX_NR;
      inv_nxt   = inv;
      case (state)
         S_IDLE: begin
            if (start) begin
               inv_nxt   = decrypt;
               cnt_load  = 1'b1;
               // A key written in the same cycle as start forces a fresh expansion.
               state_nxt = (key_valid && !key_load) ? S_INIT : S_KEYEXP;
            end
         end
         S_KEYEXP: begin
            if (abort)
               state_nxt = S_IDLE;
            else if (cnt_tc)
               state_nxt = S_INIT;
            else
               cnt_inc = 1'b1;
         end
         S_INIT: begin
            if (abort)
               state_nxt = S_IDLE;
            else begin
               state_nxt = S_ROUND;
               cnt_load  = 1'b1;
            end
         end
         S_ROUND: begin
            cnt_term = IDX_NR - AES_IDX_W'(1);
            if (abort)
               state_nxt = S_IDLE;
            else if (cnt_tc)
               state_nxt = S_FINAL;
            else
               cnt_inc = 1'b1;
         end
         S_FINAL: state_nxt = abort ? S_IDLE : S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      case (state_nxt)
         S_INIT:  rk_nxt = rk_sel('0, inv_nxt);
         S_ROUND: rk_nxt = rk_sel(cnt_nxt, inv_nxt);
         S_FINAL: rk_nxt = rk_sel(IDX_NR, inv_nxt);
         default: rk_nxt = '0;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARST) begin
      if (ARST)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // key_load while busy is deferred: the run finishes on the old keys, the cache drops on return to IDLE.
   always_ff @(posedge ACLK or posedge ARST) begin
      if (ARST) begin
         key_valid <= 1'b0;
         key_stale <= 1'b0;
      end else if (state == S_IDLE) begin
         if (key_load)
            key_valid <= 1'b0;
      end else begin
         if (state == S_KEYEXP && state_nxt == S_INIT)
            key_valid <= 1'b1;
         if (state_nxt == S_IDLE) begin
            if (key_stale || key_load)
               key_valid <= 1'b0;
            key_stale <= 1'b0;
         end else if (key_load) begin
            key_stale <= 1'b1;
         end
      end
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge ACLK or posedge ARST) begin
      if (ARST) begin
         ready    <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         inv      <= 1'b0;
         kexp_en  <= 1'b0;
         kexp_idx <= '0;
         st_load  <= 1'b0;
         st_en    <= 1'b0;
         mix_en   <= 1'b0;
         rk_idx   <= '0;
      end else begin
         ready    <= (state_nxt == S_IDLE);
         busy     <= (state_nxt != S_IDLE);
         done     <= (state_nxt == S_DONE);
         inv      <= inv_nxt;
         kexp_en  <= (state_nxt == S_KEYEXP);
         kexp_idx <= (state_nxt == S_KEYEXP) ? cnt_nxt : '0;
         st_load  <= (state_nxt == S_INIT);
         st_en    <= (state_nxt == S_INIT) || (state_nxt == S_ROUND) || (state_nxt == S_FINAL);
         mix_en   <= (state_nxt == S_ROUND);
         rk_idx   <= rk_nxt;
      end
   end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: timeline reference model checked every cycle, plus directed literal checks.
module tb_aes_round_ctrl;

   logic       ACLK = 1'b0;
   logic       ARST = 1'b1;
   logic       start = 1'b0, decrypt = 1'b0, key_load = 1'b0, abort = 1'b0;
   logic       ready, busy, done, inv, kexp_en, st_load, st_en, mix_en;
   logic [3:0] kexp_idx, rk_idx;

   int checks = 0;
   int errors = 0;

   aes_round_ctrl dut (
      .ACLK     (ACLK),
      .ARST     (ARST),
      .start    (start),
      .decrypt  (decrypt),
      .key_load (key_load),
      .abort    (abort),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .inv      (inv),
      .kexp_en  (kexp_en),
      .kexp_idx (kexp_idx),
      .st_load  (st_load),
      .st_en    (st_en),
      .mix_en   (mix_en),
      .rk_idx   (rk_idx)
   );

   always #5 ACLK = ~ACLK;

   typedef struct packed {
      logic       ready, busy, done, inv, kexp_en;
      logic [3:0] kexp_idx;
      logic       st_load, st_en, mix_en;
      logic [3:0] rk_idx;
   } outv_t;

   outv_t dut_v;
   assign dut_v = {ready, busy, done, inv, kexp_en, kexp_idx, st_load, st_en, mix_en, rk_idx};

   // Reference model: an accepted start expands into the full list of per-cycle output vectors.
   outv_t cur = 16'h8000;
   outv_t sched[$];
   outv_t e;
   bit    kv, stale;
   logic  d;

   function automatic outv_t idle_v(input logic iv);
      outv_t v = '0;
      v.ready = 1'b1;
      v.inv   = iv;
      return v;
   endfunction

   function automatic outv_t busy_v(input logic iv);
      outv_t v = '0;
      v.busy = 1'b1;
      v.inv  = iv;
      return v;
   endfunction

   always @(posedge ACLK or posedge ARST) begin
      if (ARST) begin
         sched.delete();
         kv    = 1'b0;
         stale = 1'b0;
         cur   = idle_v(1'b0);
      end else if (cur.ready) begin
         if (start) begin
            d = decrypt;
            if (!kv || key_load) begin
               for (int k = 1; k <= 10; k++) begin
                  e = busy_v(d);
                  e.kexp_en  = 1'b1;
                  e.kexp_idx = 4'(k);
                  sched.push_back(e);
               end
            end
            for (int p = 1; p <= 11; p++) begin
               e = busy_v(d);
               e.st_en   = 1'b1;
               e.st_load = (p == 1);
               e.mix_en  = (p > 1 && p < 11);
               e.rk_idx  = d ? 4'(11 - p) : 4'(p - 1);
               sched.push_back(e);
            end
            e = busy_v(d);
            e.done = 1'b1;
            sched.push_back(e);
            if (key_load) kv = 1'b0;
            cur = sched.pop_front();
         end else if (key_load) begin
            kv = 1'b0;
         end
      end else begin
         if (cur.kexp_en && cur.kexp_idx == 4'd10 && !abort) kv = 1'b1;
         if (key_load) stale = 1'b1;
         if (abort) sched.delete();
         if (sched.size() == 0) begin
            if (stale) kv = 1'b0;
            stale = 1'b0;
            cur   = idle_v(cur.inv);
         end else begin
            cur = sched.pop_front();
         end
      end
   end

   always @(negedge ACLK) begin
      checks++;
      if (dut_v !== cur) begin
         errors++;
         $display("FAIL model_cycle t=%0t: got %h, expected %h", $time, dut_v, cur);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!ready && n < 64) begin
         @(negedge ACLK);
         n++;
      end
      chk(tag, 32'(ready), 32'd1);
   endtask

   // One operation with literal expectations derived from the round schedule.
   task automatic run_op(input logic dec, input int kx, input string tag);
      int total = kx + 12;
      @(negedge ACLK);
      start   = 1'b1;
      decrypt = dec;
      @(negedge ACLK);
      start = 1'b0;
      for (int c = 1; c <= total; c++) begin
         int p = c - kx;
         chk({tag, "_kexp_idx"}, 32'(kexp_idx), (c <= kx) ? 32'(c) : 32'd0);
         chk({tag, "_rk_idx"}, 32'(rk_idx),
             (p >= 1 && p <= 11) ? (dec ? 32'(11 - p) : 32'(p - 1)) : 32'd0);
         chk({tag, "_mix_en"}, 32'(mix_en), 32'(p >= 2 && p <= 10));
         chk({tag, "_done"}, 32'(done), 32'(c == total));
         chk({tag, "_inv"}, 32'(inv), 32'(dec));
         @(negedge ACLK);
      end
      chk({tag, "_ready_after"}, 32'(ready), 32'd1);
   endtask

   initial begin
      int first, second, n;

      repeat (2) @(negedge ACLK);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_outs", 32'({done, inv, kexp_en, kexp_idx, st_load, st_en, mix_en, rk_idx}), 32'd0);
      ARST = 1'b0;

      @(negedge ACLK); key_load = 1'b1;
      @(negedge ACLK); key_load = 1'b0;
      run_op(1'b0, 10, "enc_kexp");
      run_op(1'b1, 0, "dec_cached");

      // start held high across busy: exactly one op, next one accepted as ready returns
      @(negedge ACLK);
      start = 1'b1; decrypt = 1'b0;
      first = -1; second = -1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge ACLK);
         if (st_load) begin
            if (first < 0) first = c;
            else if (second < 0) second = c;
         end
      end
      start = 1'b0;
      chk("held_first_init", 32'(first), 32'd1);
      chk("held_spacing", 32'(second - first), 32'd13);
      wait_ready("held_drain");

      // key_load mid-ROUND: run completes, next run re-expands
      @(negedge ACLK); start = 1'b1;
      @(negedge ACLK); start = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         if (c == 4) begin
            chk("kl_in_round", 32'(mix_en), 32'd1);
            key_load = 1'b1;
         end
         if (c == 5) key_load = 1'b0;
         chk("kl_done", 32'(done), 32'(c == 12));
         @(negedge ACLK);
      end
      chk("kl_ready", 32'(ready), 32'd1);
      run_op(1'b0, 10, "after_kl");

      // abort at kexp_idx=5
      @(negedge ACLK); key_load = 1'b1;
      @(negedge ACLK); key_load = 1'b0; start = 1'b1;
      @(negedge ACLK); start = 1'b0;
      n = 1;
      while (kexp_idx != 4'd5 && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      chk("abort_kexp_cycle", 32'(n), 32'd5);
      abort = 1'b1;
      @(negedge ACLK); abort = 1'b0;
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_kexp_off", 32'({kexp_en, kexp_idx}), 32'd0);
      run_op(1'b1, 10, "after_abort");

      // abort in the DONE cycle: done still pulses once
      @(negedge ACLK); start = 1'b1;
      @(negedge ACLK); start = 1'b0;
      n = 1;
      while (!done && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      chk("abort_done_cycle", 32'(n), 32'd12);
      abort = 1'b1;
      @(negedge ACLK); abort = 1'b0;
      chk("abort_done_single", 32'(done), 32'd0);
      chk("abort_done_ready", 32'(ready), 32'd1);

      // asynchronous reset between edges mid-ROUND
      @(negedge ACLK); start = 1'b1; decrypt = 1'b1;
      @(negedge ACLK); start = 1'b0;
      n = 0;
      while (!mix_en && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      chk("arst_round_seen", 32'(mix_en), 32'd1);
      #2 ARST = 1'b1;
      #1;
      chk("arst_ready", 32'(ready), 32'd1);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_outs", 32'({done, inv, kexp_en, kexp_idx, st_load, st_en, mix_en, rk_idx}), 32'd0);
      @(negedge ACLK);
      @(negedge ACLK); ARST = 1'b0;
      run_op(1'b0, 10, "after_arst");

      // randomized traffic, checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         @(negedge ACLK);
         start    = ($urandom_range(0, 3) == 0);
         decrypt  = 1'($urandom);
         key_load = ($urandom_range(0, 19) == 0);
         abort    = ($urandom_range(0, 29) == 0);
      end
      @(negedge ACLK);
      start = 1'b0; key_load = 1'b0; abort = 1'b0;
      wait_ready("rand_drain");
      repeat (2) @(negedge ACLK);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
